uart_tx_fifo_drain: RTL and testbench

UART transmitter that sits directly downstream of the byte FIFO. It pops one byte at a time via the FIFO read strobe and serialises it onto txd as a standard async frame: start bit, DATA_WIDTH data bits LSB-first, optional parity, then stop bit(s). It drains the FIFO back-to-back while data is available and tx_en is high.

---
 rtl/uart_tx_fifo_drain.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - UART transmitter that pops bytes from an upstream FIFO and serialises them
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en_i,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    output logic                  txd_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  txd_q, txd_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic baud_last;
    assign baud_last = (baud_q == BAUD_LAST);

    // Next-state, counters and registered-output values; outputs are derived
    // from the next-state values so they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        case (state_q)
            S_IDLE: begin
                if (tx_en_i && !fifo_empty_i) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = fifo_dout_i;
                par_d   = (PARITY == 1) ? ~^fifo_dout_i : ^fifo_dout_i;
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        txd_d   = 1'b1;
        rd_en_d = (state_d == S_POP);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    // State, datapath and output registers; reset drops the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign txd_o        = txd_q;
    assign fifo_rd_en_o = rd_en_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - scoreboard bench for uart_tx_fifo_drain across parity/stop variants
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;
    localparam int NDUT = 4;
    localparam int PAR_T [NDUT] = '{0, 1, 2, 0};
    localparam int STP_T [NDUT] = '{1, 1, 1, 2};

    logic clk = 1'b0;
    logic rst;
    logic tx_en;
    logic [NDUT-1:0] txd, busy, fd, rd_en, empty;
    logic [7:0] dout [NDUT];
    logic [7:0] fmem [NDUT][16];
    int rdp [NDUT];
    int wrp [NDUT];
    int rd_cnt [NDUT];
    logic [7:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx_fifo_drain #(
            .DATA_WIDTH  (8),
            .CLKS_PER_BIT(CPB),
            .PARITY      (PAR_T[g]),
            .STOP_BITS   (STP_T[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .tx_en_i     (tx_en),
            .fifo_dout_i (dout[g]),
            .fifo_empty_i(empty[g]),
            .fifo_rd_en_o(rd_en[g]),
            .txd_o       (txd[g]),
            .busy_o      (busy[g]),
            .frame_done_o(fd[g])
        );
    end

    // FIFO models: registered read data, one entry per pop strobe
    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (rd_en[g]) begin
                dout[g]   <= fmem[g][rdp[g] % 16];
                rdp[g]    <= rdp[g] + 1;
                rd_cnt[g] <= rd_cnt[g] + 1;
            end
        end
    end

    always_comb begin
        empty = '0;
        for (int g = 0; g < NDUT; g++) empty[g] = (rdp[g] == wrp[g]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        fmem[d][wrp[d] % 16] = b;
        wrp[d] = wrp[d] + 1;
        exp_q.push_back(b);
    endtask

    task automatic idle_check(input int d, input int cycles, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (txd[d] !== 1'b1 || busy[d] !== 1'b0 || rd_en[d] !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic recv_frame(input int d, input string tag, input int drop_at, output int gap);
        logic smp [64];
        logic fds [64];
        logic bzs [64];
        logic [15:0] ebits;
        logic [7:0] b;
        logic [3:0] got;
        int n, nb, len, fdn, fdpos, bzlow, k;
        n = 0;
        while (n < 500) begin
            @(negedge clk);
            if (txd[d] === 1'b0) break;
            n++;
        end
        gap = n;
        if (n >= 500) begin
            chk({tag, "_start_timeout"}, 0, 1);
            return;
        end
        nb  = 1 + 8 + ((PAR_T[d] != 0) ? 1 : 0) + STP_T[d];
        len = nb * CPB;
        smp[0] = txd[d]; fds[0] = fd[d]; bzs[0] = busy[d];
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            if (i == drop_at) tx_en = 1'b0;
            smp[i] = txd[d]; fds[i] = fd[d]; bzs[i] = busy[d];
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 0, 1);
            return;
        end
        b = exp_q.pop_front();
        ebits = '1;
        ebits[0] = 1'b0;
        for (int j = 0; j < 8; j++) ebits[1+j] = b[j];
        k = 9;
        if (PAR_T[d] == 1) ebits[k] = ~^b;
        if (PAR_T[d] == 2) ebits[k] = ^b;
        for (int i = 0; i < nb; i++) begin
            got = {smp[i*CPB+3], smp[i*CPB+2], smp[i*CPB+1], smp[i*CPB]};
            chk($sformatf("%s_bit%0d", tag, i), got, {4{ebits[i]}});
        end
        fdn = 0; fdpos = -1; bzlow = 0;
        for (int i = 0; i < len; i++) begin
            if (fds[i] === 1'b1) begin
                fdn++;
                if (fdpos < 0) fdpos = i;
            end
            if (bzs[i] !== 1'b1) bzlow++;
        end
        chk({tag, "_done_cnt"}, fdn, 1);
        chk({tag, "_done_pos"}, fdpos, len - 1);
        chk({tag, "_busy_low"}, bzlow, 0);
    endtask

    initial begin
        int gap;
        int n;
        rst = 1'b0;
        tx_en = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 4'hF);
        chk("rst_busy", busy, 4'h0);
        chk("rst_rd_en", rd_en, 4'h0);
        chk("rst_done", fd, 4'h0);
        rst = 1'b0;

        // tx_en low with data pending: nothing moves
        push(0, 8'h55);
        idle_check(0, 12, "gate_initial");
        chk("gate_initial_rd", rd_cnt[0], 0);

        // single byte, no parity
        tx_en = 1'b1;
        recv_frame(0, "single", -1, gap);
        chk("single_rd", rd_cnt[0], 1);

        // odd parity: 0x03 -> parity bit 1; even parity: 0x03 -> parity bit 0
        push(1, 8'h03);
        recv_frame(1, "odd", -1, gap);
        chk("odd_rd", rd_cnt[1], 1);
        push(2, 8'h03);
        recv_frame(2, "even", -1, gap);
        chk("even_rd", rd_cnt[2], 1);

        // two stop bits
        push(3, 8'hC3);
        recv_frame(3, "stop2", -1, gap);

        // back-to-back frames with a 3-clock high gap
        push(0, 8'hA5);
        push(0, 8'h3C);
        recv_frame(0, "b2b_a", -1, gap);
        recv_frame(0, "b2b_b", -1, gap);
        chk("b2b_gap", gap, 3);
        repeat (5) @(negedge clk);
        chk("b2b_rd", rd_cnt[0], 3);
        chk("b2b_empty", empty[0], 1'b1);
        chk("b2b_idle", busy[0], 1'b0);

        // tx_en dropped during data bit 3: frame completes, no second pop
        tx_en = 1'b0;
        push(0, 8'h81);
        push(0, 8'h42);
        idle_check(0, 10, "gate_hold0");
        tx_en = 1'b1;
        recv_frame(0, "gate_a", 17, gap);
        idle_check(0, 30, "gate_hold1");
        chk("gate_rd", rd_cnt[0], 4);
        chk("gate_pending", empty[0], 1'b0);
        tx_en = 1'b1;
        recv_frame(0, "gate_b", -1, gap);
        chk("gate_b_rd", rd_cnt[0], 5);

        // reset during data bit 5 abandons the byte; next byte starts fresh
        push(0, 8'h99);
        push(0, 8'h66);
        n = 0;
        while (n < 500 && txd[0] !== 1'b0) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_start_seen", (n < 500), 1'b1);
        repeat (25) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_txd", txd[0], 1'b1);
        chk("rst_mid_busy", busy[0], 1'b0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        recv_frame(0, "after_rst", -1, gap);
        chk("after_rst_rd", rd_cnt[0], 7);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
